// File: rtl/fifo_cascade_top.sv
// Two-stage cascaded FIFO: stage A takes writes, an internal mover drains A into
// stage B whenever B has room, and B feeds the registered read port.
module fifo_cascade_top #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [DEPTH];

  logic [ADDR_WIDTH-1:0] a_wr_ptr_q, a_wr_ptr_d, a_rd_ptr_q, a_rd_ptr_d;
  logic [ADDR_WIDTH-1:0] b_wr_ptr_q, b_wr_ptr_d, b_rd_ptr_q, b_rd_ptr_d;
  logic [ADDR_WIDTH:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic wr_acc, mv, rd_acc;

  // All decisions use registered counts only, so flags have no input-to-output path.
  always_comb begin
    wr_acc = wr_en && (a_cnt_q != CNT_FULL);
    mv     = (a_cnt_q != '0) && (b_cnt_q != CNT_FULL);
    rd_acc = rd_en && (b_cnt_q != '0);
  end

  always_comb begin
    a_wr_ptr_d = a_wr_ptr_q;
    a_rd_ptr_d = a_rd_ptr_q;
    b_wr_ptr_d = b_wr_ptr_q;
    b_rd_ptr_d = b_rd_ptr_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    dout_d     = dout_q;

    if (wr_acc) a_wr_ptr_d = a_wr_ptr_q + 1'b1;
    if (mv) begin
      a_rd_ptr_d = a_rd_ptr_q + 1'b1;
      b_wr_ptr_d = b_wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      b_rd_ptr_d = b_rd_ptr_q + 1'b1;
      dout_d     = mem_b[b_rd_ptr_q];
    end

    case ({wr_acc, mv})
      2'b10:   a_cnt_d = a_cnt_q + 1'b1;
      2'b01:   a_cnt_d = a_cnt_q - 1'b1;
      default: a_cnt_d = a_cnt_q;
    endcase

    case ({mv, rd_acc})
      2'b10:   b_cnt_d = b_cnt_q + 1'b1;
      2'b01:   b_cnt_d = b_cnt_q - 1'b1;
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_wr_ptr_q <= '0;
      a_rd_ptr_q <= '0;
      b_wr_ptr_q <= '0;
      b_rd_ptr_q <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      dout_q     <= '0;
    end else begin
      a_wr_ptr_q <= a_wr_ptr_d;
      a_rd_ptr_q <= a_rd_ptr_d;
      b_wr_ptr_q <= b_wr_ptr_d;
      b_rd_ptr_q <= b_rd_ptr_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      dout_q     <= dout_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem_a[a_wr_ptr_q] <= din;
    if (rst && mv)     mem_b[b_wr_ptr_q] <= mem_a[a_rd_ptr_q];
  end

  assign dout  = dout_q;
  assign full  = (a_cnt_q == CNT_FULL);
  assign empty = (b_cnt_q == '0);

endmodule

// File: tb/tb_fifo_cascade_top.sv
// Bench for fifo_cascade_top: directed vector table for reset/single-word behaviour,
// then fill, streaming, bursty-read and mid-operation reset sequences against a queue model.
module tb_fifo_cascade_top;

  localparam int DW    = 36;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  fifo_cascade_top #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_wr_acc = 1'b0;
  logic          m_rd_acc = 1'b0;

  typedef struct {
    logic          rst_n;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic [DW-1:0] exp_dout;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference model at the edge, compare after it.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
    logic mv;
    rst   = r;
    wr_en = w;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    if (!r) begin
      qa.delete();
      qb.delete();
      m_dout   = '0;
      m_wr_acc = 1'b0;
      m_rd_acc = 1'b0;
    end else begin
      m_wr_acc = w && (qa.size() != DEPTH);
      mv       = (qa.size() != 0) && (qb.size() != DEPTH);
      m_rd_acc = rd && (qb.size() != 0);
      if (m_rd_acc) m_dout = qb.pop_front();
      if (mv) qb.push_back(qa.pop_front());
      if (m_wr_acc) qa.push_back(d);
    end
    #1;
    check("model_dout", 64'(dout), 64'(m_dout));
    check("model_full", 64'(full), 64'(qa.size() == DEPTH));
    check("model_empty", 64'(empty), 64'(qb.size() == 0));
  endtask

  initial begin
    logic [DW-1:0] prev;
    logic [DW-1:0] next_w;
    logic [DW-1:0] last_rd;
    bit            started;
    int            first_idx;

    //          rst  wr  din      rd  dout    full  empty
    vecs[0]  = '{1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 36'h0, 1'b1, 36'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 36'h1, 1'b0, 36'h0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 36'h0, 1'b1, 36'h1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 36'h0, 1'b0, 36'h1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 36'hA, 1'b1, 36'h1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 36'h0, 1'b0, 36'h1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 36'hB, 1'b0, 36'h1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 36'h0, 1'b1, 36'hA, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 36'h0, 1'b1, 36'hB, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].wdata, vecs[i].rd);
      check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
      check($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].exp_empty));
    end

    // Fill both stages; the 1025th write must be dropped.
    for (int k = 1; k <= 2*DEPTH + 1; k++) begin
      step(1'b1, 1'b1, DW'(k), 1'b0);
      check("fill_full", 64'(full), 64'(k >= 2*DEPTH));
    end
    for (int k = 1; k <= 2*DEPTH; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("fill_rd", 64'(dout), 64'(k));
      if (k == 1) check("full_after_rd1", 64'(full), 64'd1);
      if (k == 2) check("full_after_rd2", 64'(full), 64'd0);
    end
    check("fill_drained_empty", 64'(empty), 64'd1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("fill_extra_rd_hold", 64'(dout), 64'(2*DEPTH));

    // Continuous write and read: one word per cycle after two cycles of latency.
    started   = 1'b0;
    first_idx = -1;
    prev      = '0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 1'b1, DW'(5001 + i), 1'b1);
      check("stream_full", 64'(full), 64'd0);
      if (started) begin
        check("stream_seq", 64'(dout), 64'(prev + 1'b1));
        prev = dout;
      end else if (dout == DW'(5001)) begin
        started   = 1'b1;
        first_idx = i;
        prev      = dout;
      end
    end
    check("stream_first_idx", 64'(first_idx), 64'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("stream_drained", 64'(empty), 64'd1);

    // Bursty reader: 40 cycles on, 200 off, writer always requesting.
    next_w  = DW'(20001);
    last_rd = DW'(20000);
    for (int i = 0; i < 2400; i++) begin
      step(1'b1, 1'b1, next_w, ((i % 240) < 40));
      if (m_wr_acc) next_w = next_w + 1'b1;
      if (m_rd_acc) begin
        check("burst_seq", 64'(dout), 64'(last_rd + 1'b1));
        last_rd = dout;
      end
    end
    check("burst_reached_full", 64'(next_w - last_rd - 1), 64'(2*DEPTH));

    // Mid-operation reset with 700 words stored.
    step(1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 700; k++) step(1'b1, 1'b1, DW'(k), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("pre_reset_dout", 64'(dout), 64'd1);
    step(1'b0, 1'b1, DW'(36'h77), 1'b1);
    check("mid_rst_dout", 64'(dout), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    step(1'b1, 1'b1, DW'(5), 1'b0);
    check("post_rst_wr_empty", 64'(empty), 64'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    check("post_rst_mv_empty", 64'(empty), 64'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_rst_rd", 64'(dout), 64'd5);
    check("post_rst_rd_empty", 64'(empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
